// File: rtl/perf_monitor.sv
// perf_monitor: N-core cycle/retire/branch counters plus MMIO console and finish sniffer.
// Ports: per-core pipeline events and dbus snoop in; registered counter read port; console FIFO out; done/fini/timeout/overflow flags.
module perf_monitor #(
  parameter int          NCORES     = 4,
  parameter int          CNT_W      = 64,
  parameter int          FIFO_DEPTH = 16,
  parameter bit          FINI_ALL   = 1'b1,
  parameter logic [31:0] FINI_CODE  = 32'h0002_0000,
  parameter int          TIMEOUT    = 0,
  localparam int         CW = (NCORES > 1) ? $clog2(NCORES) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NCORES-1:0]    exma_v_i,
  input  logic [NCORES-1:0]    stall_i,
  input  logic [NCORES-1:0]    stall_imem_i,
  input  logic [NCORES-1:0]    ctrl_tsfr_i,
  input  logic [NCORES-1:0]    br_misp_i,
  input  logic [NCORES-1:0]    dbus_wv_i,
  input  logic [32*NCORES-1:0] dbus_addr_i,
  input  logic [32*NCORES-1:0] dbus_wdata_i,
  input  logic                 rd_en_i,
  input  logic [CW-1:0]        rd_core_i,
  input  logic [1:0]           rd_ctr_i,
  output logic [CNT_W-1:0]     rd_data_o,
  output logic                 rd_vld_o,
  output logic                 char_vld_o,
  output logic [7:0]           char_o,
  output logic [CW-1:0]        char_core_o,
  input  logic                 char_rdy_i,
  output logic [NCORES-1:0]    done_o,
  output logic                 fini_o,
  output logic                 timeout_o,
  output logic                 overflow_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = CW + 8;

  logic [CNT_W-1:0] mcycle;
  logic [CNT_W-1:0] minstret [NCORES];
  logic [CNT_W-1:0] br_pred  [NCORES];
  logic [CNT_W-1:0] br_misp  [NCORES];

  logic [NCORES-1:0] slot_v;
  logic [7:0]        slot_d [NCORES];
  logic [CW-1:0]     rr_ptr;

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW:0]   wp;
  logic [AW:0]   rp;

  logic [NCORES-1:0] cnt_en;
  logic [NCORES-1:0] mmio;
  logic [NCORES-1:0] fin_w;
  logic [NCORES-1:0] chr_w;
  logic [NCORES-1:0] drain;
  logic              win_v;
  logic [CW-1:0]     win;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              fini_c;
  logic [CNT_W-1:0]  rd_sel;
  logic              addr_unused;

  // Only bit 31 of the address decodes MMIO space.
  assign addr_unused = ^dbus_addr_i;

  function automatic logic [CW-1:0] rr_idx(
    input logic [CW-1:0] base,
    input int            off
  );
    int s;
    s = int'(base) + off;
    if (s >= NCORES) s = s - NCORES;
    return CW'(s);
  endfunction

  always_comb begin
    cnt_en = '0;
    mmio   = '0;
    fin_w  = '0;
    chr_w  = '0;
    for (int c = 0; c < NCORES; c++) begin
      cnt_en[c] = !fini_o && !done_o[c] && !stall_imem_i[c];
      mmio[c]   = dbus_wv_i[c] && dbus_addr_i[32*c+31]
                  && !done_o[c] && !fini_o;
      fin_w[c]  = mmio[c]
                  && (dbus_wdata_i[32*c +: 32] == FINI_CODE);
      chr_w[c]  = mmio[c] && !fin_w[c];
    end
  end

  // Round-robin: first full slot at or after rr_ptr.
  always_comb begin
    win_v = 1'b0;
    win   = '0;
    for (int i = 0; i < NCORES; i++) begin
      if (!win_v && slot_v[rr_idx(rr_ptr, i)]) begin
        win_v = 1'b1;
        win   = rr_idx(rr_ptr, i);
      end
    end
  end

  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW])
                 && (wp[AW-1:0] == rp[AW-1:0]);
  assign pop   = !empty && char_rdy_i;
  assign push  = win_v && (!full || pop);

  always_comb begin
    drain = '0;
    if (push) drain[win] = 1'b1;
  end

  assign char_vld_o = !empty;
  assign {char_core_o, char_o} = empty ? '0 : mem[rp[AW-1:0]];

  assign fini_c = FINI_ALL ? (&done_o) : (|done_o);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mcycle    <= '0;
      timeout_o <= 1'b0;
      fini_o    <= 1'b0;
      done_o    <= '0;
      for (int c = 0; c < NCORES; c++) begin
        minstret[c] <= '0;
        br_pred[c]  <= '0;
        br_misp[c]  <= '0;
      end
    end else begin
      if (!fini_o) mcycle <= mcycle + CNT_W'(1);
      if (TIMEOUT != 0 && mcycle == CNT_W'(TIMEOUT - 1))
        timeout_o <= 1'b1;
      fini_o <= fini_o | fini_c;
      done_o <= done_o | fin_w;
      for (int c = 0; c < NCORES; c++) begin
        if (cnt_en[c] && exma_v_i[c]) begin
          if (!stall_i[c])
            minstret[c] <= minstret[c] + CNT_W'(1);
          if (ctrl_tsfr_i[c])
            br_pred[c] <= br_pred[c] + CNT_W'(1);
          if (ctrl_tsfr_i[c] && br_misp_i[c])
            br_misp[c] <= br_misp[c] + CNT_W'(1);
        end
      end
    end
  end

  // A slot drained this edge may refill from the same-cycle write.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slot_v     <= '0;
      rr_ptr     <= '0;
      overflow_o <= 1'b0;
      for (int c = 0; c < NCORES; c++) slot_d[c] <= '0;
    end else begin
      if (push)
        rr_ptr <= (int'(win) == NCORES - 1) ? '0 : win + CW'(1);
      for (int c = 0; c < NCORES; c++) begin
        if (chr_w[c] && (!slot_v[c] || drain[c])) begin
          slot_v[c] <= 1'b1;
          slot_d[c] <= dbus_wdata_i[32*c +: 8];
        end else begin
          if (drain[c]) slot_v[c] <= 1'b0;
          if (chr_w[c]) overflow_o <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wp[AW-1:0]] <= {win, slot_d[win]};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + (AW+1)'(1);
      if (pop)  rp <= rp + (AW+1)'(1);
    end
  end

  always_comb begin
    rd_sel = '0;
    if (int'(rd_core_i) < NCORES) begin
      case (rd_ctr_i)
        2'd0:    rd_sel = mcycle;
        2'd1:    rd_sel = minstret[rd_core_i];
        2'd2:    rd_sel = br_pred[rd_core_i];
        default: rd_sel = br_misp[rd_core_i];
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_vld_o  <= 1'b0;
      rd_data_o <= '0;
    end else begin
      rd_vld_o <= rd_en_i;
      if (rd_en_i) rd_data_o <= rd_sel;
    end
  end

endmodule

// File: tb/tb_perf_monitor.sv
// tb_perf_monitor: random and directed stimulus for perf_monitor.
// A queue-based reference model is checked against the DUT every cycle.
module tb_perf_monitor;

  localparam int          N     = 4;
  localparam int          DEPTH = 16;
  localparam int          TMO   = 50;
  localparam logic [31:0] FC    = 32'h0002_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst        = 1'b1;
  logic [N-1:0]    exma_v     = '0;
  logic [N-1:0]    stall      = '0;
  logic [N-1:0]    stall_imem = '0;
  logic [N-1:0]    ctrl       = '0;
  logic [N-1:0]    misp       = '0;
  logic [N-1:0]    wv         = '0;
  logic [32*N-1:0] addr       = '0;
  logic [32*N-1:0] wdata      = '0;
  logic            rd_en      = 1'b0;
  logic [1:0]      rd_core    = '0;
  logic [1:0]      rd_ctr     = '0;
  logic            rdy        = 1'b0;

  logic [63:0]  rd_data;
  logic         rd_vld;
  logic         char_vld;
  logic [7:0]   char_b;
  logic [1:0]   char_core;
  logic [N-1:0] done;
  logic         fini;
  logic         timeout;
  logic         overflow;

  perf_monitor #(
    .NCORES(N), .CNT_W(64), .FIFO_DEPTH(DEPTH),
    .FINI_ALL(1'b1), .FINI_CODE(FC), .TIMEOUT(TMO)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .exma_v_i(exma_v), .stall_i(stall),
    .stall_imem_i(stall_imem), .ctrl_tsfr_i(ctrl),
    .br_misp_i(misp), .dbus_wv_i(wv),
    .dbus_addr_i(addr), .dbus_wdata_i(wdata),
    .rd_en_i(rd_en), .rd_core_i(rd_core), .rd_ctr_i(rd_ctr),
    .rd_data_o(rd_data), .rd_vld_o(rd_vld),
    .char_vld_o(char_vld), .char_o(char_b),
    .char_core_o(char_core), .char_rdy_i(rdy),
    .done_o(done), .fini_o(fini),
    .timeout_o(timeout), .overflow_o(overflow)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Reference model
  longint unsigned m_cyc;
  longint unsigned m_ins [N];
  longint unsigned m_bp  [N];
  longint unsigned m_bm  [N];
  longint unsigned m_rd;
  logic [N-1:0]    m_done;
  bit              m_fini, m_to, m_ovf, m_rv;
  bit              m_sf [N];
  logic [7:0]      m_sc [N];
  int              m_ptr;
  logic [9:0]      m_q [$];

  task automatic model_reset();
    m_cyc = 0; m_rd = 0; m_done = '0;
    m_fini = 0; m_to = 0; m_ovf = 0; m_rv = 0;
    m_ptr = 0; m_q.delete();
    for (int c = 0; c < N; c++) begin
      m_ins[c] = 0; m_bp[c] = 0; m_bm[c] = 0;
      m_sf[c] = 0; m_sc[c] = '0;
    end
  endtask

  task automatic model_step();
    bit           pop;
    bit           all_done;
    int           win;
    int           c;
    logic [N-1:0] nd;
    pop = (m_q.size() != 0) && rdy;
    m_rv = rd_en;
    if (rd_en) begin
      case (rd_ctr)
        2'd0:    m_rd = m_cyc;
        2'd1:    m_rd = m_ins[rd_core];
        2'd2:    m_rd = m_bp[rd_core];
        default: m_rd = m_bm[rd_core];
      endcase
    end
    if (m_cyc == longint'(TMO - 1)) m_to = 1;
    all_done = &m_done;
    for (int k = 0; k < N; k++) begin
      if (!m_fini && !m_done[k] && !stall_imem[k] && exma_v[k]) begin
        if (!stall[k]) m_ins[k]++;
        if (ctrl[k]) begin
          m_bp[k]++;
          if (misp[k]) m_bm[k]++;
        end
      end
    end
    if (!m_fini) m_cyc++;
    if (pop) void'(m_q.pop_front());
    win = -1;
    for (int k = 0; k < N; k++) begin
      c = (m_ptr + k) % N;
      if (win < 0 && m_sf[c]) win = c;
    end
    if (win >= 0 && m_q.size() < DEPTH) begin
      m_q.push_back({2'(win), m_sc[win]});
      m_sf[win] = 0;
      m_ptr = (win + 1) % N;
    end
    nd = m_done;
    for (int k = 0; k < N; k++) begin
      if (wv[k] && addr[32*k+31] && !m_done[k] && !m_fini) begin
        if (wdata[32*k +: 32] == FC) nd[k] = 1'b1;
        else if (m_sf[k]) m_ovf = 1;
        else begin
          m_sf[k] = 1;
          m_sc[k] = wdata[32*k +: 8];
        end
      end
    end
    if (all_done) m_fini = 1;
    m_done = nd;
  endtask

  initial model_reset();

  always @(posedge clk) begin
    if (rst) model_reset();
    else     model_step();
  end

  bit         chk_en = 0;
  int         ncyc   = 0;
  logic [9:0] log_q [$];
  int         log_t [$];

  always @(negedge clk) begin
    ncyc++;
    if (chk_en) begin
      chk("rd_vld", 64'(rd_vld), 64'(m_rv));
      if (m_rv) chk("rd_data", rd_data, m_rd);
      chk("char_vld", 64'(char_vld), 64'(m_q.size() != 0));
      if (m_q.size() != 0)
        chk("char", 64'({char_core, char_b}), 64'(m_q[0]));
      chk("done", 64'(done), 64'(m_done));
      chk("fini", 64'(fini), 64'(m_fini));
      chk("timeout", 64'(timeout), 64'(m_to));
      chk("overflow", 64'(overflow), 64'(m_ovf));
      if (char_vld && rdy) begin
        log_q.push_back({char_core, char_b});
        log_t.push_back(ncyc);
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic rd(input logic [1:0] core, input logic [1:0] ctr,
                    output logic [63:0] v);
    rd_en = 1'b1; rd_core = core; rd_ctr = ctr;
    step();
    rd_en = 1'b0;
    chk("rd_pulse", 64'(rd_vld), 64'd1);
    v = rd_data;
  endtask

  task automatic clear_in();
    exma_v = '0; stall = '0; stall_imem = '0;
    ctrl = '0; misp = '0; wv = '0;
    addr = '0; wdata = '0; rd_en = 1'b0;
  endtask

  task automatic rand_cycle(input int rdy_pct, input bit allow_fc);
    exma_v = N'($urandom);
    stall  = N'($urandom);
    ctrl   = N'($urandom);
    misp   = N'($urandom);
    stall_imem = ($urandom_range(0, 9) == 0) ? N'($urandom) : '0;
    for (int c = 0; c < N; c++) begin
      wv[c] = ($urandom_range(0, 3) == 0);
      addr[32*c +: 32]  = $urandom;
      wdata[32*c +: 32] = $urandom;
      if (allow_fc && $urandom_range(0, 19) == 0)
        wdata[32*c +: 32] = FC;
      else if (!allow_fc && wdata[32*c +: 32] == FC)
        wdata[32*c +: 32] = FC ^ 32'h1;
    end
    rdy     = ($urandom_range(0, 99) < rdy_pct);
    rd_en   = 1'($urandom);
    rd_core = 2'($urandom);
    rd_ctr  = 2'($urandom);
    step();
  endtask

  logic [63:0] v;
  int          pcts [6] = '{90, 0, 50, 100, 10, 70};

  initial begin
    step(3);
    chk_en = 1;
    chk("rst_flags",
        64'({char_vld, done, fini, timeout, overflow, rd_vld}), 64'd0);
    rst = 1'b0;

    step(40);
    chk("idle_flags",
        64'({char_vld, done, fini, timeout, overflow}), 64'd0);
    step(9);
    chk("timeout_49", 64'(timeout), 64'd0);
    step(1);
    chk("timeout_50", 64'(timeout), 64'd1);
    step(50);
    rd(2'd0, 2'd0, v);
    chk("mcycle_100", v, 64'd100);
    rd(2'd0, 2'd1, v);
    chk("minstret0_0", v, 64'd0);

    for (int i = 0; i < 10; i++) begin
      exma_v[1] = 1'b1;
      stall[1]  = (i == 0 || i == 4 || i == 7);
      ctrl[1]   = (i == 1 || i == 2 || i == 5 || i == 8);
      misp[1]   = (i == 5);
      step();
    end
    clear_in();
    rd(2'd1, 2'd1, v); chk("c1_minstret", v, 64'd7);
    rd(2'd1, 2'd2, v); chk("c1_br_pred", v, 64'd4);
    rd(2'd1, 2'd3, v); chk("c1_br_misp", v, 64'd1);
    stall_imem[1] = 1'b1; exma_v[1] = 1'b1;
    ctrl[1] = 1'b1; misp[1] = 1'b1;
    step(5);
    clear_in();
    rd(2'd1, 2'd1, v); chk("imem_minstret", v, 64'd7);
    rd(2'd1, 2'd2, v); chk("imem_br_pred", v, 64'd4);
    rd(2'd1, 2'd3, v); chk("imem_br_misp", v, 64'd1);

    log_q.delete(); log_t.delete();
    rdy = 1'b1;
    wv = 4'b1101;
    addr[31:0]   = 32'h8000_0000; wdata[31:0]   = 32'h41;
    addr[95:64]  = 32'h8000_0000; wdata[95:64]  = 32'h42;
    addr[127:96] = 32'h8000_0000; wdata[127:96] = 32'h43;
    step();
    clear_in();
    step(6);
    chk("abc_count", 64'(log_q.size()), 64'd3);
    if (log_q.size() == 3) begin
      chk("abc_0", 64'(log_q[0]), 64'h041);
      chk("abc_1", 64'(log_q[1]), 64'h242);
      chk("abc_2", 64'(log_q[2]), 64'h343);
      chk("abc_consec",
          64'((log_t[1] == log_t[0] + 1) && (log_t[2] == log_t[1] + 1)),
          64'd1);
    end

    rdy = 1'b0;
    for (int i = 1; i <= 18; i++) begin
      wv[0] = 1'b1;
      addr[31:0]  = 32'h8000_0000;
      wdata[31:0] = 32'(i);
      step();
    end
    clear_in();
    step();
    chk("ovf_set", 64'(overflow), 64'd1);
    log_q.delete(); log_t.delete();
    rdy = 1'b1;
    step(25);
    chk("drain_count", 64'(log_q.size()), 64'd17);
    for (int i = 0; i < 17 && i < log_q.size(); i++)
      chk("drain_order", 64'(log_q[i]), 64'(i + 1));

    for (int b = 0; b < 12; b++)
      for (int k = 0; k < 250; k++)
        rand_cycle(pcts[b % 6], 1'b0);
    clear_in();
    rdy = 1'b0;
    step(2);

    wv[0] = 1'b1; addr[31:0] = 32'h8000_0000; wdata[31:0] = FC;
    step();
    clear_in();
    chk("done_0001", 64'(done), 64'h1);
    chk("fini_early", 64'(fini), 64'd0);
    step(3);
    wv = 4'b1110;
    for (int c = 1; c < N; c++) begin
      addr[32*c +: 32]  = 32'h8000_0000;
      wdata[32*c +: 32] = FC;
    end
    step();
    clear_in();
    chk("done_all", 64'(done), 64'hf);
    chk("fini_lag", 64'(fini), 64'd0);
    step();
    chk("fini_set", 64'(fini), 64'd1);
    for (int k = 0; k < 300; k++) rand_cycle(60, 1'b1);

    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k < 100; k++) rand_cycle(5, 1'b0);
    clear_in();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_flags",
        64'({char_vld, done, fini, timeout, overflow}), 64'd0);
    rd(2'd2, 2'd0, v);
    chk("mid_rst_mcycle", v, 64'd0);
    step(5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
